// File: rtl/riscv_ifetch_pkg.sv
// riscv_ifetch_pkg
// Shared types for the instruction-fetch block.
//  - ifetch_state_e : fetch controller states (IDLE, REQ, WAIT, DROP)
//  - ifetch_entry_t : one fetch-queue entry {pc, instr, misalign}
//  - IFETCH_WIDTH / IFETCH_ILEN : default PC and instruction widths
//  - ifetch_entry() : builds a queue entry from its fields
package riscv_ifetch_pkg;

    localparam int unsigned IFETCH_WIDTH = 64;
    localparam int unsigned IFETCH_ILEN  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } ifetch_state_e;

    typedef struct packed {
        logic [IFETCH_WIDTH-1:0] pc;
        logic [IFETCH_ILEN-1:0]  instr;
        logic                    misalign;
    } ifetch_entry_t;

    function automatic ifetch_entry_t ifetch_entry(
        input logic [IFETCH_WIDTH-1:0] pc,
        input logic [IFETCH_ILEN-1:0]  instr,
        input logic                    misalign
    );
        ifetch_entry_t e;
        e.pc       = pc;
        e.instr    = instr;
        e.misalign = misalign;
        return e;
    endfunction

endpackage

// File: rtl/riscv_ifetch_fifo.sv
// riscv_ifetch_fifo
// DEPTH-entry FIFO of ifetch_entry_t feeding decode.
//  clk_i, rst_i (async, active-high), clear_i (synchronous flush, wins over push/pop),
//  push_i/push_data_i, pop_i, head_o (entry at read pointer), full_o, empty_o.
// Push while full is accepted only together with a pop, keeping the count unchanged.
// Storage is reset to zero so the head reads as all-zero out of reset.
module riscv_ifetch_fifo
    import riscv_ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          push_i,
    input  ifetch_entry_t push_data_i,
    input  logic          pop_i,
    output ifetch_entry_t head_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    ifetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   rptr_q;
    logic [AW:0]     count_q;
    logic            do_push_s;
    logic            do_pop_s;

    assign full_o    = (count_q == CNT_FULL);
    assign empty_o   = (count_q == '0);
    assign head_o    = mem_q[rptr_q];
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & (~full_o | do_pop_s);

    // Storage, pointers and occupancy count; pointers wrap because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wptr_q] <= push_data_i;
                wptr_q        <= wptr_q + PTR_ONE;
            end
            if (do_pop_s) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/riscv_ifetch.sv
// riscv_ifetch
// Instruction-fetch stage between riscv_pc and decode. Issues at most one outstanding
// imem request for the current PC, queues {pc, instr, misalign} for decode, and drops
// the PC stall for exactly one cycle per accepted fetch or redirect (flush).
// Ports:
//  i_riscv_ifetch_clk/rst          clock, async active-high reset
//  i_riscv_ifetch_pc               current PC;  o_riscv_ifetch_stallpc  PC hold (0 = advance)
//  i_riscv_ifetch_flush            redirect: clear queue, abandon in-flight fetch
//  o_riscv_ifetch_imem_req/addr    request;     i_riscv_ifetch_imem_gnt  accept
//  i_riscv_ifetch_imem_rvalid/rdata response
//  o_riscv_ifetch_valid/instr/pcout/misalign  queue head;  i_riscv_ifetch_ready  consume
// Build option: RISCV_IFETCH_MISALIGN_CHECK_EN -- a PC with pc[1:0]!=0 is not requested;
// a {pc, 0, misalign=1} entry is queued directly and the PC advances. Undefined: always request.
module riscv_ifetch
    import riscv_ifetch_pkg::*;
#(
    parameter int unsigned WIDTH = IFETCH_WIDTH,
    parameter int unsigned ILEN  = IFETCH_ILEN,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_riscv_ifetch_clk,
    input  logic             i_riscv_ifetch_rst,
    input  logic [WIDTH-1:0] i_riscv_ifetch_pc,
    output logic             o_riscv_ifetch_stallpc,
    input  logic             i_riscv_ifetch_flush,
    output logic             o_riscv_ifetch_imem_req,
    output logic [WIDTH-1:0] o_riscv_ifetch_imem_addr,
    input  logic             i_riscv_ifetch_imem_gnt,
    input  logic             i_riscv_ifetch_imem_rvalid,
    input  logic [ILEN-1:0]  i_riscv_ifetch_imem_rdata,
    output logic             o_riscv_ifetch_valid,
    output logic [ILEN-1:0]  o_riscv_ifetch_instr,
    output logic [WIDTH-1:0] o_riscv_ifetch_pcout,
    output logic             o_riscv_ifetch_misalign,
    input  logic             i_riscv_ifetch_ready
);

    ifetch_state_e    state_q;
    ifetch_state_e    state_d;
    logic [WIDTH-1:0] pend_pc_q;
    logic [WIDTH-1:0] pend_pc_d;
    logic             req_s;
    logic             mis_push_s;
    logic             push_s;
    ifetch_entry_t    push_data_s;
    ifetch_entry_t    head_s;
    logic             full_s;
    logic             empty_s;
    logic             pop_s;
    logic             accept_s;

    assign accept_s = req_s & i_riscv_ifetch_imem_gnt;
    assign pop_s    = ~empty_s & i_riscv_ifetch_ready;

    // State register and PC of the outstanding request.
    always_ff @(posedge i_riscv_ifetch_clk or posedge i_riscv_ifetch_rst) begin
        if (i_riscv_ifetch_rst) begin
            state_q   <= IDLE;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // Next-state logic; flush takes priority and must still drain a granted request via DROP.
    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        case (state_q)
            IDLE: begin
                if (i_riscv_ifetch_flush) begin
                    state_d = IDLE;
                end else begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (accept_s) begin
                    pend_pc_d = i_riscv_ifetch_pc;
                    state_d   = i_riscv_ifetch_flush ? DROP : WAIT;
                end else begin
                    state_d   = i_riscv_ifetch_flush ? IDLE : REQ;
                end
            end
            WAIT: begin
                if (i_riscv_ifetch_imem_rvalid) begin
                    state_d = i_riscv_ifetch_flush ? IDLE : REQ;
                end else begin
                    state_d = i_riscv_ifetch_flush ? DROP : WAIT;
                end
            end
            DROP: begin
                if (i_riscv_ifetch_imem_rvalid) begin
                    state_d = IDLE;
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request, queue-push and PC-stall outputs; a full queue blocks new work so a push never overflows.
    always_comb begin
        req_s                    = 1'b0;
        mis_push_s               = 1'b0;
        push_s                   = 1'b0;
        push_data_s              = '0;
        o_riscv_ifetch_imem_addr = '0;
        case (state_q)
            REQ: begin
                o_riscv_ifetch_imem_addr = i_riscv_ifetch_pc;
`ifdef RISCV_IFETCH_MISALIGN_CHECK_EN
                if (i_riscv_ifetch_pc[1:0] != 2'b00) begin
                    mis_push_s  = ~full_s;
                    push_s      = ~full_s & ~i_riscv_ifetch_flush;
                    push_data_s = ifetch_entry(i_riscv_ifetch_pc, {ILEN{1'b0}}, 1'b1);
                end else begin
                    req_s = ~full_s;
                end
`else
                req_s = ~full_s;
`endif
            end
            WAIT: begin
                if (i_riscv_ifetch_imem_rvalid & ~i_riscv_ifetch_flush) begin
                    push_s      = 1'b1;
                    push_data_s = ifetch_entry(pend_pc_q, i_riscv_ifetch_imem_rdata, 1'b0);
                end else begin
                    push_s      = 1'b0;
                end
            end
            default: begin
                req_s = 1'b0;
            end
        endcase
    end

    assign o_riscv_ifetch_imem_req = req_s;
    assign o_riscv_ifetch_stallpc  = ~(accept_s | mis_push_s | i_riscv_ifetch_flush);

    riscv_ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (i_riscv_ifetch_clk),
        .rst_i       (i_riscv_ifetch_rst),
        .clear_i     (i_riscv_ifetch_flush),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .full_o      (full_s),
        .empty_o     (empty_s)
    );

    assign o_riscv_ifetch_valid    = ~empty_s;
    assign o_riscv_ifetch_instr    = head_s.instr;
    assign o_riscv_ifetch_pcout    = head_s.pc;
    assign o_riscv_ifetch_misalign = head_s.misalign;

endmodule

// File: tb/tb_riscv_ifetch.sv
// tb_riscv_ifetch
// Self-checking bench for riscv_ifetch. The bench plays riscv_pc (advances its PC by 4, or
// to the redirect target, whenever it sees stallpc=0) and the imem; expected queue entries
// are pushed to a scoreboard when the response is driven and popped when decode consumes.
module tb_riscv_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc;
    logic        stallpc;
    logic        flush;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        valid;
    logic [31:0] instr;
    logic [63:0] pcout;
    logic        misalign;
    logic        ready;

    logic [63:0] flush_target;
    logic [63:0] gpc;
    int          total = 0;
    int          bad   = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    riscv_ifetch #(.WIDTH(64), .ILEN(32), .DEPTH(4)) dut (
        .i_riscv_ifetch_clk         (clk),
        .i_riscv_ifetch_rst         (rst),
        .i_riscv_ifetch_pc          (pc),
        .o_riscv_ifetch_stallpc     (stallpc),
        .i_riscv_ifetch_flush       (flush),
        .o_riscv_ifetch_imem_req    (imem_req),
        .o_riscv_ifetch_imem_addr   (imem_addr),
        .i_riscv_ifetch_imem_gnt    (gnt),
        .i_riscv_ifetch_imem_rvalid (rvalid),
        .i_riscv_ifetch_imem_rdata  (rdata),
        .o_riscv_ifetch_valid       (valid),
        .o_riscv_ifetch_instr       (instr),
        .o_riscv_ifetch_pcout       (pcout),
        .o_riscv_ifetch_misalign    (misalign),
        .i_riscv_ifetch_ready       (ready)
    );

    always #5 clk = ~clk;

    // Called at a negedge: behaves like riscv_pc across the next rising edge.
    task automatic tick();
        logic st;
        logic fl;
        st = stallpc;
        fl = flush;
        @(posedge clk);
        #1;
        if (!st) pc = fl ? flush_target : pc + 64'd4;
    endtask

    task automatic sb_push(input logic [63:0] p, input logic [31:0] i, input logic m);
        exp_t x;
        x.pc = p; x.instr = i; x.mis = m;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        rst = 1'b1; pc = 64'h0; flush = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        rdata = 32'h0; ready = 1'b0; flush_target = 64'h0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++; if (stallpc !== 1'b1) begin bad++; $display("FAIL rst_stall got=%0h want=1", stallpc); end
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h want=0", imem_req); end
            total++; if (imem_addr !== 64'h0) begin bad++; $display("FAIL rst_addr got=%0h want=0", imem_addr); end
            total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h want=0", valid); end
            total++; if (instr !== 32'h0 || pcout !== 64'h0 || misalign !== 1'b0) begin
                bad++; $display("FAIL rst_head got=%0h/%0h/%0h want=0/0/0", instr, pcout, misalign); end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(negedge clk);
        total++; if (stallpc !== 1'b1 || imem_req !== 1'b0) begin
            bad++; $display("FAIL idle_stall got stall=%0h req=%0h want 1/0", stallpc, imem_req); end
        tick();
    endtask

    task automatic test_single();
        pc = 64'h80000; gnt = 1'b1;
        @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== 64'h80000) begin
            bad++; $display("FAIL single_req got req=%0h addr=%0h want 1/80000", imem_req, imem_addr); end
        total++; if (stallpc !== 1'b0) begin bad++; $display("FAIL single_stall0 got=%0h want=0", stallpc); end
        gpc = pc;
        tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h00000013; sb_push(gpc, rdata, 1'b0);
        @(negedge clk);
        total++; if (stallpc !== 1'b1 || valid !== 1'b0) begin
            bad++; $display("FAIL single_wait got stall=%0h valid=%0h want 1/0", stallpc, valid); end
        tick();
        rvalid = 1'b0; ready = 1'b1;
        @(negedge clk);
        e = sb.pop_front();
        total++; if (valid !== 1'b1 || instr !== e.instr || pcout !== e.pc || misalign !== e.mis) begin
            bad++; $display("FAIL single_head got v=%0h i=%0h pc=%0h want 1/%0h/%0h", valid, instr, pcout, e.instr, e.pc); end
        tick();
        ready = 1'b0;
        @(negedge clk);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL single_popped got=%0h want=0", valid); end
        tick();
    endtask

    task automatic test_full();
        pc = 64'h80000;
        for (int i = 0; i < 4; i++) begin
            gnt = 1'b1;
            @(negedge clk);
            total++; if (imem_req !== 1'b1 || imem_addr !== pc) begin
                bad++; $display("FAIL full_req%0d got req=%0h addr=%0h want 1/%0h", i, imem_req, imem_addr, pc); end
            gpc = pc;
            tick();
            gnt = 1'b0; rvalid = 1'b1; rdata = 32'h10000000 + 32'(i); sb_push(gpc, rdata, 1'b0);
            @(negedge clk);
            tick();
            rvalid = 1'b0;
        end
        gnt = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++; if (imem_req !== 1'b0 || stallpc !== 1'b1) begin
                bad++; $display("FAIL full_hold got req=%0h stall=%0h want 0/1", imem_req, stallpc); end
            tick();
        end
        gnt = 1'b0; ready = 1'b1;
        @(negedge clk);
        e = sb.pop_front();
        total++; if (valid !== 1'b1 || instr !== e.instr || pcout !== e.pc) begin
            bad++; $display("FAIL full_pop got i=%0h pc=%0h want %0h/%0h", instr, pcout, e.instr, e.pc); end
        tick();
        ready = 1'b0;
        @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== 64'h80010) begin
            bad++; $display("FAIL full_resume got req=%0h addr=%0h want 1/80010", imem_req, imem_addr); end
        tick();
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            total++; if (valid !== 1'b1 || instr !== e.instr || pcout !== e.pc) begin
                bad++; $display("FAIL full_drain%0d got v=%0h i=%0h pc=%0h want 1/%0h/%0h", i, valid, instr, pcout, e.instr, e.pc); end
            tick();
        end
        ready = 1'b0;
        @(negedge clk);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL full_empty got=%0h want=0", valid); end
        tick();
    endtask

    task automatic test_flush();
        gnt = 1'b1;
        @(negedge clk);
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL flush_req got=%0h want=1", imem_req); end
        tick();
        gnt = 1'b0; flush = 1'b1; flush_target = 64'h90000;
        @(negedge clk);
        total++; if (stallpc !== 1'b0 || imem_req !== 1'b0) begin
            bad++; $display("FAIL flush_stall got stall=%0h req=%0h want 0/0", stallpc, imem_req); end
        tick();
        flush = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++; if (imem_req !== 1'b0 || stallpc !== 1'b1 || valid !== 1'b0) begin
                bad++; $display("FAIL flush_drop got req=%0h stall=%0h v=%0h want 0/1/0", imem_req, stallpc, valid); end
            tick();
        end
        rvalid = 1'b1; rdata = 32'hDEADBEEF;
        @(negedge clk);
        tick();
        rvalid = 1'b0;
        @(negedge clk);
        total++; if (valid !== 1'b0 || imem_req !== 1'b0) begin
            bad++; $display("FAIL flush_dropped got v=%0h req=%0h want 0/0", valid, imem_req); end
        tick();
        @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== 64'h90000 || valid !== 1'b0) begin
            bad++; $display("FAIL flush_resume got req=%0h addr=%0h v=%0h want 1/90000/0", imem_req, imem_addr, valid); end
        tick();
    endtask

    task automatic test_stream();
        int npop;
        npop = 0;
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            gnt = 1'b1;
            @(negedge clk);
            total++; if (imem_req !== 1'b1 || imem_addr !== pc) begin
                bad++; $display("FAIL stream_req%0d got req=%0h addr=%0h want 1/%0h", i, imem_req, imem_addr, pc); end
            if (i > 0) begin
                e = sb.pop_front(); npop++;
                total++; if (valid !== 1'b1 || instr !== e.instr || pcout !== e.pc) begin
                    bad++; $display("FAIL stream_out%0d got v=%0h i=%0h pc=%0h want 1/%0h/%0h", i, valid, instr, pcout, e.instr, e.pc); end
            end
            gpc = pc;
            tick();
            gnt = 1'b0; rvalid = 1'b1; rdata = gpc[31:0] ^ 32'h00A50000; sb_push(gpc, rdata, 1'b0);
            @(negedge clk);
            total++; if (valid !== 1'b0) begin bad++; $display("FAIL stream_cnt%0d got v=%0h want 0", i, valid); end
            tick();
            rvalid = 1'b0;
        end
        @(negedge clk);
        e = sb.pop_front(); npop++;
        total++; if (valid !== 1'b1 || instr !== e.instr || pcout !== e.pc) begin
            bad++; $display("FAIL stream_last got v=%0h i=%0h pc=%0h want 1/%0h/%0h", valid, instr, pcout, e.instr, e.pc); end
        tick();
        ready = 1'b0;
        @(negedge clk);
        total++; if (valid !== 1'b0 || npop != 6) begin
            bad++; $display("FAIL stream_loss got v=%0h pops=%0d want 0/6", valid, npop); end
        tick();
    endtask

    task automatic test_misalign();
        pc = 64'h80002;
`ifdef RISCV_IFETCH_MISALIGN_CHECK_EN
        @(negedge clk);
        total++; if (imem_req !== 1'b0 || stallpc !== 1'b0) begin
            bad++; $display("FAIL mis_noreq got req=%0h stall=%0h want 0/0", imem_req, stallpc); end
        tick();
        pc = 64'h80010; ready = 1'b1;
        @(negedge clk);
        total++; if (valid !== 1'b1 || pcout !== 64'h80002 || misalign !== 1'b1 || instr !== 32'h0) begin
            bad++; $display("FAIL mis_entry got v=%0h pc=%0h m=%0h i=%0h want 1/80002/1/0", valid, pcout, misalign, instr); end
        tick();
`else
        gnt = 1'b1;
        @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== 64'h80002 || stallpc !== 1'b0) begin
            bad++; $display("FAIL mis_req got req=%0h addr=%0h stall=%0h want 1/80002/0", imem_req, imem_addr, stallpc); end
        tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h00000093;
        @(negedge clk);
        tick();
        rvalid = 1'b0; ready = 1'b1;
        @(negedge clk);
        total++; if (valid !== 1'b1 || pcout !== 64'h80002 || misalign !== 1'b0 || instr !== 32'h93) begin
            bad++; $display("FAIL mis_entry got v=%0h pc=%0h m=%0h i=%0h want 1/80002/0/93", valid, pcout, misalign, instr); end
        tick();
`endif
        ready = 1'b0;
    endtask

    task automatic test_reset_midwait();
        gnt = 1'b1;
        @(negedge clk);
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rw_req got=%0h want=1", imem_req); end
        tick();
        gnt = 1'b0; rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0; rvalid = 1'b1; rdata = 32'h00000BAD;
        @(negedge clk);
        total++; if (imem_req !== 1'b0 || stallpc !== 1'b1 || valid !== 1'b0) begin
            bad++; $display("FAIL rw_idle got req=%0h stall=%0h v=%0h want 0/1/0", imem_req, stallpc, valid); end
        tick();
        @(negedge clk);
        total++; if (imem_req !== 1'b1 || valid !== 1'b0) begin
            bad++; $display("FAIL rw_req2 got req=%0h v=%0h want 1/0", imem_req, valid); end
        tick();
        rvalid = 1'b0;
        @(negedge clk);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rw_stray got v=%0h want 0", valid); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_flush();
        test_stream();
        test_misalign();
        test_reset_midwait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
